// File: rtl/mem_lock_pkg.sv
// Shared types, default parameters and the rotate-priority pick helper for
// the N-way memory lock arbiter.
//   state_t        : arbiter FSM states
//   DEF_*          : default parameter values for mem_lock_arbiter_n
//   rr_pick_onehot : one-hot pick of the first eligible bit scanning up from ptr
package mem_lock_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  localparam int unsigned DEF_NUM_CORES = 4;
  localparam int unsigned DEF_MAX_HOLD  = 255;
  localparam int unsigned DEF_CNT_W     = 8;
  localparam int unsigned MAX_CORES     = 16;

  // Double-width rotate: replicate the n-bit vector above itself, shift down
  // by ptr, and the first set bit in the low n bits is the winner.
  function automatic logic [MAX_CORES-1:0] rr_pick_onehot(
    input logic [MAX_CORES-1:0] elig,
    input int unsigned          ptr,
    input int unsigned          n
  );
    logic [2*MAX_CORES-1:0] dbl;
    logic [MAX_CORES-1:0]   res;
    logic                   found;
    int unsigned            k;
    res   = '0;
    found = 1'b0;
    k     = 0;
    dbl   = ({MAX_CORES'(0), elig} << n) | {MAX_CORES'(0), elig};
    dbl   = dbl >> ptr;
    for (int unsigned i = 0; i < MAX_CORES; i++) begin
      if ((i < n) && !found && dbl[i]) begin
        found = 1'b1;
        k     = ptr + i;
        if (k >= n) k = k - n;
        res[k] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker.
//   elig      in  N      eligible requesters
//   ptr       in  IDX_W  index with highest priority
//   pick      out N      one-hot winner (zero when nothing eligible)
//   pick_idx  out IDX_W  index of the winner
//   any_valid out 1      at least one requester eligible
module rr_priority_pick
  import mem_lock_pkg::*;
#(
  parameter int unsigned N     = DEF_NUM_CORES,
  parameter int unsigned IDX_W = $clog2(DEF_NUM_CORES)
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any_valid
);

  logic [MAX_CORES-1:0] full;

  always_comb begin
    full      = rr_pick_onehot(MAX_CORES'(elig), 32'(ptr), N);
    pick      = full[N-1:0];
    any_valid = |full;
    pick_idx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mem_lock_arbiter_n.sv
// N-way round-robin memory lock arbiter with direct handoff and hold timeout.
//   clk           in  1          rising-edge clock
//   rst           in  1          synchronous active-high reset
//   req           in  NUM_CORES  level lock requests
//   grant         out NUM_CORES  registered one-hot (or zero) grant
//   lock_valid    out 1          registered OR of grant
//   owner_idx     out IDX_W      current owner; last owner when idle
//   hold_cnt      out CNT_W      saturating hold time of current owner
//   timeout_pulse out 1          one cycle when a revocation takes effect
//   blocked       out NUM_CORES  cores barred until they drop req
module mem_lock_arbiter_n
  import mem_lock_pkg::*;
#(
  parameter  int unsigned NUM_CORES = DEF_NUM_CORES,
  parameter  int unsigned MAX_HOLD  = DEF_MAX_HOLD,
  parameter  int unsigned CNT_W     = DEF_CNT_W,
  localparam int unsigned IDX_W     = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] req,
  output logic [NUM_CORES-1:0] grant,
  output logic                 lock_valid,
  output logic [IDX_W-1:0]     owner_idx,
  output logic [CNT_W-1:0]     hold_cnt,
  output logic                 timeout_pulse,
  output logic [NUM_CORES-1:0] blocked
);

  state_t               state_q, state_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [NUM_CORES-1:0] blk_q, blk_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 tp_q, tp_d;
  logic                 lv_q;

  logic                 owner_req, rel, tmo, hand;
  logic [IDX_W-1:0]     ptr_rr, pick_ptr, pick_idx;
  logic [NUM_CORES-1:0] elig, pick;
  logic                 any_valid;

  // Event decode; the owner is excluded from elig so a revoked owner never
  // wins its own handoff.
  always_comb begin
    owner_req = req[owner_q];
    rel       = (state_q == HELD) && !owner_req;
    tmo       = (MAX_HOLD != 0) && (state_q == HELD) && owner_req &&
                (cnt_q == CNT_W'(MAX_HOLD - 1));
    hand      = rel || tmo;
    ptr_rr    = (owner_q == IDX_W'(NUM_CORES - 1)) ? '0 : owner_q + IDX_W'(1);
    pick_ptr  = hand ? ptr_rr : ptr_q;
    elig      = req & ~blk_q & ~grant_q;
  end

  rr_priority_pick #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_pick (
    .elig      (elig),
    .ptr       (pick_ptr),
    .pick      (pick),
    .pick_idx  (pick_idx),
    .any_valid (any_valid)
  );

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    tp_d    = 1'b0;
    blk_d   = blk_q & req;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = HELD;
          grant_d = pick;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      HELD: begin
        if (hand) begin
          ptr_d = ptr_rr;
          cnt_d = '0;
          if (tmo) begin
            tp_d           = 1'b1;
            blk_d[owner_q] = 1'b1;
          end
          if (any_valid) begin
            grant_d = pick;
            owner_d = pick_idx;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      blk_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tp_q    <= 1'b0;
      lv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      blk_q   <= blk_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tp_q    <= tp_d;
      lv_q    <= |grant_d;
    end
  end

  assign grant         = grant_q;
  assign lock_valid    = lv_q;
  assign owner_idx     = owner_q;
  assign hold_cnt      = cnt_q;
  assign timeout_pulse = tp_q;
  assign blocked       = blk_q;

endmodule
